// File: rtl/sdo_frame_rx_if.sv
// rtl/sdo_frame_rx_if.sv - serial input, word output and fault pulse bundle for sdo_frame_rx
interface sdo_frame_rx_if #(parameter int WORD_W = 8);
  logic              fbi;
  logic              sdo;
  logic              par_en;
  logic [WORD_W-1:0] word_out;
  logic              word_valid;
  logic              word_ready;
  logic              par_err;
  logic              ovr_err;
  logic              tmo_err;
  logic              busy;

  modport master (
    output fbi, sdo, par_en, word_ready,
    input  word_out, word_valid, par_err, ovr_err, tmo_err, busy
  );

  modport slave (
    input  fbi, sdo, par_en, word_ready,
    output word_out, word_valid, par_err, ovr_err, tmo_err, busy
  );
endinterface

// File: rtl/sdo_frame_rx.sv
// rtl/sdo_frame_rx.sv - SDO stream deserializer with parity, overrun and gap-timeout checks
module sdo_frame_rx #(
  parameter int WORD_W  = 8,
  parameter int TIMEOUT = 127
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          iclr,
  sdo_frame_rx_if.slave bus
);
  typedef enum logic [1:0] {IDLE, DATA, PAR} state_t;

  localparam logic [5:0] LAST_CNT = 6'(WORD_W - 1);
  localparam logic [7:0] TMO_LIM  = 8'(TIMEOUT);

  state_t            state;
  logic [WORD_W-1:0] shreg;
  logic [5:0]        bit_cnt;
  logic [7:0]        gap_cnt;
  logic              par_lat;

  logic [WORD_W-1:0] shifted;
  logic              can_load;

  assign shifted  = {shreg[WORD_W-2:0], bus.sdo};
  // A word may land if the buffer is empty or is being drained on this same edge.
  assign can_load = !bus.word_valid || bus.word_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      shreg          <= '0;
      bit_cnt        <= '0;
      gap_cnt        <= '0;
      par_lat        <= 1'b0;
      bus.word_out   <= '0;
      bus.word_valid <= 1'b0;
      bus.par_err    <= 1'b0;
      bus.ovr_err    <= 1'b0;
      bus.tmo_err    <= 1'b0;
      bus.busy       <= 1'b0;
    end else if (iclr) begin
      state          <= IDLE;
      shreg          <= '0;
      bit_cnt        <= '0;
      gap_cnt        <= '0;
      par_lat        <= 1'b0;
      bus.word_out   <= '0;
      bus.word_valid <= 1'b0;
      bus.par_err    <= 1'b0;
      bus.ovr_err    <= 1'b0;
      bus.tmo_err    <= 1'b0;
      bus.busy       <= 1'b0;
    end else begin
      bus.par_err <= 1'b0;
      bus.ovr_err <= 1'b0;
      bus.tmo_err <= 1'b0;
      if (bus.word_valid && bus.word_ready) begin
        bus.word_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (bus.fbi) begin
            shreg    <= {{(WORD_W-1){1'b0}}, bus.sdo};
            bit_cnt  <= 6'd1;
            gap_cnt  <= '0;
            par_lat  <= bus.par_en;
            state    <= DATA;
            bus.busy <= 1'b1;
          end
        end

        DATA: begin
          if (bus.fbi) begin
            gap_cnt <= '0;
            shreg   <= shifted;
            bit_cnt <= bit_cnt + 6'd1;
            if (bit_cnt == LAST_CNT) begin
              if (par_lat) begin
                state <= PAR;
              end else begin
                state    <= IDLE;
                bus.busy <= 1'b0;
                if (can_load) begin
                  bus.word_out   <= shifted;
                  bus.word_valid <= 1'b1;
                end else begin
                  bus.ovr_err <= 1'b1;
                end
              end
            end
          end else if (gap_cnt == TMO_LIM) begin
            bus.tmo_err <= 1'b1;
            state       <= IDLE;
            bus.busy    <= 1'b0;
          end else begin
            gap_cnt <= gap_cnt + 8'd1;
          end
        end

        PAR: begin
          if (bus.fbi) begin
            gap_cnt  <= '0;
            state    <= IDLE;
            bus.busy <= 1'b0;
            // Even parity: data bits plus parity bit must XOR to zero.
            if (^{shreg, bus.sdo}) begin
              bus.par_err <= 1'b1;
            end else if (can_load) begin
              bus.word_out   <= shreg;
              bus.word_valid <= 1'b1;
            end else begin
              bus.ovr_err <= 1'b1;
            end
          end else if (gap_cnt == TMO_LIM) begin
            bus.tmo_err <= 1'b1;
            state       <= IDLE;
            bus.busy    <= 1'b0;
          end else begin
            gap_cnt <= gap_cnt + 8'd1;
          end
        end

        default: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_sdo_frame_rx.sv
// tb/tb_sdo_frame_rx.sv - directed self-checking bench for sdo_frame_rx
module tb_sdo_frame_rx;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic iclr = 1'b0;
  int   tests = 0;
  int   fails = 0;
  logic err_seen;
  logic [7:0] words [4];

  sdo_frame_rx_if #(.WORD_W(8)) bus ();

  sdo_frame_rx #(.WORD_W(8), .TIMEOUT(127)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .iclr  (iclr),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Shifts out the low n bits of val, MSB first, with FBI held high.
  task automatic send(input logic [31:0] val, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      bus.fbi = 1'b1;
      bus.sdo = val[i];
      cyc();
    end
    bus.fbi = 1'b0;
    bus.sdo = 1'b0;
  endtask

  task automatic idle(input int n);
    bus.fbi = 1'b0;
    for (int i = 0; i < n; i++) begin
      cyc();
      err_seen = err_seen | bus.tmo_err | bus.par_err | bus.ovr_err;
    end
  endtask

  initial begin
    bus.fbi = 1'b0;
    bus.sdo = 1'b0;
    bus.par_en = 1'b0;
    bus.word_ready = 1'b0;
    err_seen = 1'b0;
    words[0] = 8'h01;
    words[1] = 8'h80;
    words[2] = 8'hFF;
    words[3] = 8'h00;

    cyc();
    cyc();
    check("rst_valid", bus.word_valid, 0);
    check("rst_word", bus.word_out, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_errs", {bus.par_err, bus.ovr_err, bus.tmo_err}, 0);
    rst_n = 1'b1;
    cyc();

    // Async reset mid-frame with a word already buffered
    send(8'h3C, 8);
    check("pre_rst_word", bus.word_out, 8'h3C);
    send(5'b11111, 5);
    check("pre_rst_busy", bus.busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_busy", bus.busy, 0);
    check("async_rst_valid", bus.word_valid, 0);
    check("async_rst_word", bus.word_out, 0);
    #2 rst_n = 1'b1;
    cyc();
    send(8'h96, 8);
    check("post_rst_valid", bus.word_valid, 1);
    check("post_rst_word", bus.word_out, 8'h96);

    // Sync clear mid-frame, with FBI high in the same cycle
    send(5'b10101, 5);
    check("pre_clr_busy", bus.busy, 1);
    iclr = 1'b1;
    bus.fbi = 1'b1;
    bus.sdo = 1'b1;
    cyc();
    iclr = 1'b0;
    bus.fbi = 1'b0;
    check("clr_busy", bus.busy, 0);
    check("clr_valid", bus.word_valid, 0);
    check("clr_word", bus.word_out, 0);
    send(8'h5A, 8);
    check("post_clr_word", bus.word_out, 8'h5A);
    bus.word_ready = 1'b1;
    cyc();
    check("post_clr_drain", bus.word_valid, 0);
    bus.word_ready = 1'b0;

    // Normal frame with parity
    bus.par_en = 1'b1;
    send(8'hA5, 8);
    bus.par_en = 1'b0;
    check("par_wait_busy", bus.busy, 1);
    check("par_wait_valid", bus.word_valid, 0);
    send(1'b0, 1);
    check("par_ok_valid", bus.word_valid, 1);
    check("par_ok_word", bus.word_out, 8'hA5);
    check("par_ok_busy", bus.busy, 0);
    check("par_ok_perr", bus.par_err, 0);

    // Overrun: A5 left unread
    send(8'h3C, 8);
    check("ovr_pulse", bus.ovr_err, 1);
    check("ovr_keep_word", bus.word_out, 8'hA5);
    check("ovr_keep_valid", bus.word_valid, 1);
    cyc();
    check("ovr_pulse_end", bus.ovr_err, 0);
    send(7'b0011110, 7);
    bus.word_ready = 1'b1;
    send(1'b0, 1);
    check("drain_load_word", bus.word_out, 8'h3C);
    check("drain_load_valid", bus.word_valid, 1);
    check("drain_load_ovr", bus.ovr_err, 0);
    cyc();
    check("accept_drop", bus.word_valid, 0);
    bus.word_ready = 1'b0;

    // Parity error
    bus.par_en = 1'b1;
    send(8'hA5, 8);
    bus.par_en = 1'b0;
    send(1'b1, 1);
    check("perr_pulse", bus.par_err, 1);
    check("perr_valid", bus.word_valid, 0);
    check("perr_busy", bus.busy, 0);
    check("perr_ovr", bus.ovr_err, 0);
    cyc();
    check("perr_pulse_end", bus.par_err, 0);

    // Gap of exactly TIMEOUT cycles is tolerated
    err_seen = 1'b0;
    send(3'b101, 3);
    idle(127);
    check("gap127_noerr", err_seen, 0);
    check("gap127_busy", bus.busy, 1);
    send(5'b00101, 5);
    check("gap127_valid", bus.word_valid, 1);
    check("gap127_word", bus.word_out, 8'hA5);
    check("gap127_tmo", bus.tmo_err, 0);
    bus.word_ready = 1'b1;
    cyc();
    bus.word_ready = 1'b0;

    // TIMEOUT+1 idle cycles abort the frame
    err_seen = 1'b0;
    send(3'b101, 3);
    idle(127);
    check("gap128_early", err_seen, 0);
    cyc();
    check("tmo_pulse", bus.tmo_err, 1);
    check("tmo_busy", bus.busy, 0);
    cyc();
    check("tmo_pulse_end", bus.tmo_err, 0);
    send(5'b00101, 5);
    check("tmo_restart_busy", bus.busy, 1);
    check("tmo_restart_valid", bus.word_valid, 0);
    send(3'b111, 3);
    check("tmo_restart_word", bus.word_out, 8'h2F);
    check("tmo_restart_vld", bus.word_valid, 1);
    bus.word_ready = 1'b1;
    cyc();
    check("tmo_restart_drain", bus.word_valid, 0);

    // Back-to-back frames on continuous FBI
    err_seen = 1'b0;
    for (int w = 0; w < 4; w++) begin
      for (int b = 7; b >= 0; b--) begin
        bus.fbi = 1'b1;
        bus.sdo = words[w][b];
        cyc();
        err_seen = err_seen | bus.tmo_err | bus.par_err | bus.ovr_err;
        check($sformatf("b2b_valid_w%0d_b%0d", w, b), bus.word_valid, (b == 0));
        if (b == 0) check($sformatf("b2b_word_%0d", w), bus.word_out, words[w]);
      end
    end
    bus.fbi = 1'b0;
    cyc();
    check("b2b_last_drop", bus.word_valid, 0);
    check("b2b_noerr", err_seen, 0);
    check("b2b_busy", bus.busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
